// File: rtl/at_resp_rx.sv
// Receive-side parser for the sensor module's AT responses: recognises OK, ERROR,
// +HEART:<dec> and +SPO2:<dec> lines (CR LF terminated) and latches parsed values.
module at_resp_rx #(
  parameter int VAL_W       = 16,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic             resp_ok,
  output logic             resp_err,
  output logic [VAL_W-1:0] heart_val,
  output logic             heart_upd,
  output logic [VAL_W-1:0] spo2_val,
  output logic             spo2_upd,
  output logic             frame_err
);

  // state  | meaning
  // S_IDLE | waiting for the first byte of a line
  // S_TAG  | after '+', matching HEART / SPO2 tag up to ':'
  // S_NUM  | accumulating decimal digits until CR
  // S_WORD | matching OK / ERROR letter by letter until CR
  // S_LF   | CR seen on a good line, LF commits it
  // S_SKIP | discarding an echo, unknown or malformed line until LF
  typedef enum logic [2:0] {S_IDLE, S_TAG, S_NUM, S_WORD, S_LF, S_SKIP} state_t;
  typedef enum logic [1:0] {K_OK, K_ERR, K_HEART, K_SPO2} kind_t;

  localparam int PW = VAL_W + 4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] SAT_MAX  = {4'b0000, {VAL_W{1'b1}}};

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_O     = 8'h4F;
  localparam logic [7:0] CH_E     = 8'h45;

  function automatic logic [7:0] heart_ch(input logic [2:0] i);
    case (i)
      3'd0:    heart_ch = 8'h48; // H
      3'd1:    heart_ch = 8'h45; // E
      3'd2:    heart_ch = 8'h41; // A
      3'd3:    heart_ch = 8'h52; // R
      3'd4:    heart_ch = 8'h54; // T
      default: heart_ch = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] spo2_ch(input logic [2:0] i);
    case (i)
      3'd0:    spo2_ch = 8'h53; // S
      3'd1:    spo2_ch = 8'h50; // P
      3'd2:    spo2_ch = 8'h4F; // O
      3'd3:    spo2_ch = 8'h32; // 2
      default: spo2_ch = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] word_ch(input logic is_err, input logic [2:0] i);
    if (is_err) begin
      case (i)
        3'd0:    word_ch = 8'h45; // E
        3'd1:    word_ch = 8'h52; // R
        3'd2:    word_ch = 8'h52; // R
        3'd3:    word_ch = 8'h4F; // O
        3'd4:    word_ch = 8'h52; // R
        default: word_ch = 8'h00;
      endcase
    end else begin
      case (i)
        3'd0:    word_ch = 8'h4F; // O
        3'd1:    word_ch = 8'h4B; // K
        default: word_ch = 8'h00;
      endcase
    end
  endfunction

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [2:0]       idx_q, idx_d;
  logic             arm_h_q, arm_h_d;
  logic             arm_s_q, arm_s_d;
  logic             err_word_q, err_word_d;
  logic             have_dig_q, have_dig_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             resp_ok_q, resp_ok_d;
  logic             resp_err_q, resp_err_d;
  logic             heart_upd_q, heart_upd_d;
  logic             spo2_upd_q, spo2_upd_d;
  logic             frame_err_q, frame_err_d;
  logic [VAL_W-1:0] heart_val_q, heart_val_d;
  logic [VAL_W-1:0] spo2_val_q, spo2_val_d;

  logic          run, timeout, bad, h_ok, s_ok, is_digit;
  logic [2:0]    word_len;
  logic [PW-1:0] prod;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    idx_d       = idx_q;
    arm_h_d     = arm_h_q;
    arm_s_d     = arm_s_q;
    err_word_d  = err_word_q;
    have_dig_d  = have_dig_q;
    acc_d       = acc_q;
    tmo_d       = tmo_q;
    resp_ok_d   = 1'b0;
    resp_err_d  = 1'b0;
    heart_upd_d = 1'b0;
    spo2_upd_d  = 1'b0;
    frame_err_d = 1'b0;
    heart_val_d = heart_val_q;
    spo2_val_d  = spo2_val_q;
    bad         = 1'b0;
    h_ok        = 1'b0;
    s_ok        = 1'b0;
    is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    word_len    = err_word_q ? 3'd5 : 3'd2;
    prod        = ({4'b0000, acc_q} * PW'(10)) + PW'(rx_data[3:0]);

    run     = (state_q != S_IDLE);
    timeout = run && (tmo_q == TMO_LAST);
    tmo_d   = (rx_done || timeout || !run) ? '0 : tmo_q + 1'b1;

    // A timeout takes precedence over a byte strobed in the same cycle.
    if (timeout) begin
      state_d     = S_IDLE;
      acc_d       = '0;
      frame_err_d = (state_q != S_SKIP);
    end else if (rx_done) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == CH_PLUS) begin
            state_d = S_TAG;
            idx_d   = 3'd0;
            arm_h_d = 1'b1;
            arm_s_d = 1'b1;
          end else if (rx_data == CH_O || rx_data == CH_E) begin
            state_d    = S_WORD;
            err_word_d = (rx_data == CH_E);
            idx_d      = 3'd1;
          end else if (rx_data != CH_CR && rx_data != CH_LF) begin
            state_d = S_SKIP;
          end
        end
        S_TAG: begin
          if (rx_data == CH_COLON) begin
            if (arm_h_q && idx_q == 3'd5) begin
              state_d    = S_NUM;
              kind_d     = K_HEART;
              acc_d      = '0;
              have_dig_d = 1'b0;
            end else if (arm_s_q && idx_q == 3'd4) begin
              state_d    = S_NUM;
              kind_d     = K_SPO2;
              acc_d      = '0;
              have_dig_d = 1'b0;
            end else begin
              bad = 1'b1;
            end
          end else begin
            h_ok    = arm_h_q && (idx_q < 3'd5) && (rx_data == heart_ch(idx_q));
            s_ok    = arm_s_q && (idx_q < 3'd4) && (rx_data == spo2_ch(idx_q));
            arm_h_d = h_ok;
            arm_s_d = s_ok;
            if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
            if (!h_ok && !s_ok) bad = 1'b1;
          end
        end
        S_NUM: begin
          if (is_digit) begin
            // Saturate instead of wrapping; a saturated value re-saturates on every digit.
            acc_d      = (prod > SAT_MAX) ? {VAL_W{1'b1}} : prod[VAL_W-1:0];
            have_dig_d = 1'b1;
          end else if (rx_data == CH_CR && have_dig_q) begin
            state_d = S_LF;
          end else begin
            bad = 1'b1;
          end
        end
        S_WORD: begin
          if (idx_q == word_len && rx_data == CH_CR) begin
            state_d = S_LF;
            kind_d  = err_word_q ? K_ERR : K_OK;
          end else if (idx_q < word_len && rx_data == word_ch(err_word_q, idx_q)) begin
            idx_d = idx_q + 3'd1;
          end else begin
            bad = 1'b1;
          end
        end
        S_LF: begin
          if (rx_data == CH_LF) begin
            state_d = S_IDLE;
            case (kind_q)
              K_OK:    resp_ok_d = 1'b1;
              K_ERR:   resp_err_d = 1'b1;
              K_HEART: begin
                heart_upd_d = 1'b1;
                heart_val_d = acc_q;
              end
              default: begin
                spo2_upd_d = 1'b1;
                spo2_val_d = acc_q;
              end
            endcase
          end else begin
            bad = 1'b1;
          end
        end
        S_SKIP: begin
          if (rx_data == CH_LF) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (bad) begin
        frame_err_d = 1'b1;
        state_d     = (rx_data == CH_LF) ? S_IDLE : S_SKIP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      kind_q      <= K_OK;
      idx_q       <= '0;
      arm_h_q     <= 1'b0;
      arm_s_q     <= 1'b0;
      err_word_q  <= 1'b0;
      have_dig_q  <= 1'b0;
      acc_q       <= '0;
      tmo_q       <= '0;
      resp_ok_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      heart_upd_q <= 1'b0;
      spo2_upd_q  <= 1'b0;
      frame_err_q <= 1'b0;
      heart_val_q <= '0;
      spo2_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      idx_q       <= idx_d;
      arm_h_q     <= arm_h_d;
      arm_s_q     <= arm_s_d;
      err_word_q  <= err_word_d;
      have_dig_q  <= have_dig_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      resp_ok_q   <= resp_ok_d;
      resp_err_q  <= resp_err_d;
      heart_upd_q <= heart_upd_d;
      spo2_upd_q  <= spo2_upd_d;
      frame_err_q <= frame_err_d;
      heart_val_q <= heart_val_d;
      spo2_val_q  <= spo2_val_d;
    end
  end

  assign resp_ok   = resp_ok_q;
  assign resp_err  = resp_err_q;
  assign heart_upd = heart_upd_q;
  assign spo2_upd  = spo2_upd_q;
  assign frame_err = frame_err_q;
  assign heart_val = heart_val_q;
  assign spo2_val  = spo2_val_q;

endmodule

// File: tb/tb_at_resp_rx.sv
// Directed bench for at_resp_rx: sends AT response lines byte by byte and
// checks pulses, pulse counts and latched values against hand-computed results.
module tb_at_resp_rx;
  localparam int VAL_W = 16;
  localparam int TMO   = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_done = 1'b0;
  logic             resp_ok, resp_err, heart_upd, spo2_upd, frame_err;
  logic [VAL_W-1:0] heart_val, spo2_val;

  at_resp_rx #(.VAL_W(VAL_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .resp_ok(resp_ok), .resp_err(resp_err), .heart_val(heart_val),
    .heart_upd(heart_upd), .spo2_val(spo2_val), .spo2_upd(spo2_upd),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cnt[5];
  logic [4:0] pv;
  // pv bit order: ok, err, heart_upd, spo2_upd, frame_err
  assign pv = {resp_ok, resp_err, heart_upd, spo2_upd, frame_err};

  always @(negedge clk)
    for (int k = 0; k < 5; k++) if (pv[k]) cnt[k]++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Returns at the negedge right after the last byte's strobe edge.
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (i != 0) idle(1);
      send_byte(s[i]);
    end
  endtask

  task automatic line(input string tag, input string s,
                      input logic [4:0] exp_now, input logic [4:0] exp_cnt);
    int base[5];
    logic [31:0] got_cnt, want_cnt;
    #1;
    base = cnt;
    send_str(s);
    #1;
    chk({tag, ".now"}, 32'(pv), 32'(exp_now));
    idle(4);
    #1;
    got_cnt  = '0;
    want_cnt = '0;
    for (int k = 0; k < 5; k++) begin
      got_cnt[4*k +: 4]  = 4'(cnt[k] - base[k]);
      want_cnt[4*k +: 4] = {3'b000, exp_cnt[k]};
    end
    chk({tag, ".cnt"}, got_cnt, want_cnt);
  endtask

  int b0;

  initial begin
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    #2;
    chk("reset.pulses", 32'(pv), 32'd0);
    chk("reset.heart", 32'(heart_val), 32'd0);
    chk("reset.spo2", 32'(spo2_val), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    line("heart72", "+HEART:72\r\n", 5'b00100, 5'b00100);
    chk("heart72.val", 32'(heart_val), 32'd72);
    chk("heart72.spo2", 32'(spo2_val), 32'd0);

    line("spo2_98", "+SPO2:98\r\n", 5'b00010, 5'b00010);
    chk("spo2_98.val", 32'(spo2_val), 32'd98);
    chk("spo2_98.heart", 32'(heart_val), 32'd72);

    line("ok", "OK\r\n", 5'b10000, 5'b10000);
    line("error", "ERROR\r\n", 5'b01000, 5'b01000);
    line("echo", "AT+SPO2\r\n", 5'b00000, 5'b00000);
    line("blank", "\r\n", 5'b00000, 5'b00000);
    line("hear", "+HEAR:5\r\n", 5'b00000, 5'b00001);
    line("nodig", "+HEART:\r\n", 5'b00000, 5'b00001);
    chk("nodig.heart", 32'(heart_val), 32'd72);

    line("lfbad", "+HE\n", 5'b00001, 5'b00001);
    line("ok_after_lf", "OK\r\n", 5'b10000, 5'b10000);
    line("okx", "OKX\r\n", 5'b00000, 5'b00001);

    line("sat", "+HEART:99999\r\n", 5'b00100, 5'b00100);
    chk("sat.val", 32'(heart_val), 32'd65535);
    chk("sat.spo2", 32'(spo2_val), 32'd98);
    line("lead0", "+HEART:007\r\n", 5'b00100, 5'b00100);
    chk("lead0.val", 32'(heart_val), 32'd7);
    line("max", "+HEART:65535\r\n", 5'b00100, 5'b00100);
    chk("max.val", 32'(heart_val), 32'd65535);
    line("badnum", "+SPO2:12X\r\n", 5'b00000, 5'b00001);
    chk("badnum.spo2", 32'(spo2_val), 32'd98);

    // Timeout: pulse lands about TMO cycles after the last byte.
    send_str("+HEART:7");
    #1;
    b0 = cnt[0];
    idle(990);
    #1;
    chk("tmo.early", 32'(cnt[0] - b0), 32'd0);
    idle(40);
    #1;
    chk("tmo.fire", 32'(cnt[0] - b0), 32'd1);
    line("after_tmo", "+SPO2:95\r\n", 5'b00010, 5'b00010);
    chk("after_tmo.spo2", 32'(spo2_val), 32'd95);
    chk("after_tmo.heart", 32'(heart_val), 32'd65535);

    send_str("+HEART:12");
    idle(1);
    rst_n = 1'b0;
    #2;
    chk("rst.pulses", 32'(pv), 32'd0);
    chk("rst.heart", 32'(heart_val), 32'd0);
    chk("rst.spo2", 32'(spo2_val), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    line("rst34", "+HEART:34\r\n", 5'b00100, 5'b00100);
    chk("rst34.val", 32'(heart_val), 32'd34);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
